imem_boot_loader: RTL
=====================

# imem_boot_loader

Instruction-memory owner with a byte-stream loader. It accepts a framed program image on a valid/ready byte interface and assembles little-endian 32-bit words into an internal 64-word instruction RAM. It serves the processor's combinational fetch port and holds the core stopped until a load completes with a matching checksum. This block is the writer side of the fetch path, replacing file-initialised instruction memory.

## Interface
- `DEPTH`, 64: instruction RAM depth in words.
- `FADDR_W`, 8: fetch byte-address width. Word index is `fetch_addr[FADDR_W-1:2]`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  loader byte valid.
- `in_data`  in  8  loader byte.
- `in_ready`  out  1  loader can accept; a byte transfers when `in_valid && in_ready` at a clock edge.
- `reload`  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- `fetch_addr`  in  FADDR_W  processor fetch byte address.
- `fetch_instr`  out  32  instruction word; combinational.
- `core_run`  out  1  high enables the processor. Low holds it.
- `load_done`  out  1  level; last load succeeded.
- `load_err`  out  1  level; last load failed.
- `words_loaded`  out  7  count of words written in the current or last load.

## Operation
- **Frame:** header byte N (word count), then 4·N payload bytes with the LSB of each word first, then 1 checksum byte. The checksum is the XOR of all payload bytes; the header is excluded.
- **Valid header:** 1 ≤ N ≤ DEPTH. N = 0 or N > DEPTH moves to ERROR on acceptance of the header.
- **FSM states:** IDLE, LOAD, CHECK, DONE, ERROR.
  - IDLE: wait for the header. On accepted header: clear the word index, byte counter, running XOR and `words_loaded`, then go to LOAD (or to ERROR if N is invalid).
  - LOAD: shift each accepted byte into a 32-bit assembly register at byte lane `byte_cnt` and XOR it into the checksum. On the 4th byte, write the word at the word index, then increment the index and `words_loaded`. After word N-1 is written, go to CHECK.
  - CHECK: on the accepted byte, go to DONE if it equals the running XOR, otherwise go to ERROR.
  - DONE and ERROR: `in_ready` = 0. A `reload` pulse moves to IDLE and clears `load_done` and `load_err`.
- **Outputs by state:**
  - `in_ready` = 1 in IDLE, LOAD and CHECK.
  - `core_run` = 1 only in DONE.
  - `fetch_instr` = RAM[word index] while `core_run` = 1, otherwise 32'h00000013 (NOP).
- **RAM contents:** not cleared by reset or reload. Words at index ≥ N retain prior contents.
- **Fetch index range:** a fetch index ≥ DEPTH returns NOP.
- **Reset (including mid-load):**
  - State goes to IDLE.
  - `in_ready`=0 while reset is asserted, then 1 from the first clock edge after release.
  - `core_run`=0, `load_done`=0, `load_err`=0, `words_loaded`=0, `fetch_instr`=NOP.
  - A partially written image is abandoned; RAM keeps whatever was written.

## Timing
- One byte per cycle maximum. `in_ready` depends only on state, never on `in_valid`.
- The RAM write is synchronous and takes effect on the same edge that accepts the 4th byte. The word is readable on the next cycle, but it is only visible on `fetch_instr` once in DONE.
- The checksum byte is accepted at edge T. `core_run` and `load_done` (match), or `load_err` (mismatch), are high from T.
- `reload` in DONE drops `core_run` on the next edge. `reload` in IDLE, LOAD or CHECK is ignored.
- `reload` together with `in_valid` in DONE: the byte is not accepted (`in_ready`=0), and the state is IDLE after the edge.

## Structure
- Shared package: state enum (5 states), `NOP_INSTR` = 32'h00000013, `DEPTH` default.
- One sub-module `imem_ram`: DEPTH×32, one synchronous write port, one asynchronous read port.
- Everything else lives in the top: FSM, byte counter, assembly register, XOR accumulator and output muxing.

## Test plan
- **Single word:** reset, then send 01, 13 05 00 00, 16.
  - `load_done`=1 and `core_run`=1.
  - `fetch_addr`=0 gives 32'h00000513.
  - `fetch_addr`=4 gives stale RAM content (RAM is not cleared).
- **Bad checksum:** send 01, 13 05 00 00, 17.
  - `load_err`=1, `core_run`=0, `fetch_instr`=NOP, `in_ready`=0.
  - A `reload` pulse returns to IDLE with `in_ready`=1.
- **Invalid header:** send header 00, then header 41 (65).
  - Each goes to ERROR on the header cycle.
  - `words_loaded`=0.
- **Backpressure and gaps:** send a 2-word image with `in_valid` toggling randomly.
  - Words land at indices 0 and 1 with correct byte order.
  - `words_loaded`=2.
- **Reset mid-load:** assert `rst_n`=0 after the 6th payload byte.
  - All outputs take their reset values.
  - A fresh 1-word load then succeeds.
- **Reload while running:** in DONE, pulse `reload` with `in_valid`=1 on the same cycle.
  - `core_run`=0 on the next cycle.
  - That byte is not consumed.
  - The next header is accepted.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// imem_boot_loader_pkg : shared state encoding and constants for the boot loader
// Revision 1.0
// ============================================================================
package imem_boot_loader_pkg;

    localparam int          DEPTH_DEFAULT = 64;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// imem_boot_loader_if : valid/ready byte stream carrying the program image
// Revision 1.0
// ============================================================================
interface imem_boot_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/imem_boot_loader_ram.sv
`default_nettype none
// ============================================================================
// imem_ram : DEPTH x 32 instruction RAM, synchronous write, asynchronous read
// Revision 1.0
// ============================================================================
module imem_ram
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 6
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [31:0]   wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents deliberately survive reset so a stale image stays fetchable
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// imem_boot_loader : framed byte-stream loader feeding the instruction RAM,
//                    gating the core until a checksummed image is in place
// Revision 1.0
// ============================================================================
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int FADDR_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    imem_boot_loader_if.slave       ld,
    input  wire logic               reload,
    input  wire logic [FADDR_W-1:0] fetch_addr,
    output logic      [31:0]        fetch_instr,
    output logic                    core_run,
    output logic                    load_done,
    output logic                    load_err,
    output logic      [6:0]         words_loaded
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_live;
    logic [1:0]      r_byte_cnt;
    logic [AW-1:0]   r_word_idx;
    logic [AW-1:0]   r_last_idx;
    logic [7:0]      r_xor;
    logic [23:0]     r_asm;
    logic [6:0]      r_words;

    logic            w_accept;
    logic            w_hdr_ok;
    logic            w_ram_we;
    logic            w_fetch_ok;
    logic [31:0]     w_hdr32;
    logic [31:0]     w_fidx32;
    logic [31:0]     w_ram_rdata;
    logic [AW-1:0]   w_raddr;
    logic            unused_fetch_lsb;

    // r_live keeps in_ready low until the first edge after reset release
    assign ld.in_ready = r_live && (r_state inside {ST_IDLE, ST_LOAD, ST_CHECK});
    assign w_accept    = ld.in_valid && ld.in_ready;

    assign w_hdr32  = {24'd0, ld.in_data};
    assign w_hdr_ok = (w_hdr32 != 32'd0) && (w_hdr32 <= 32'(DEPTH));
    assign w_ram_we = w_accept && (r_state == ST_LOAD) && (r_byte_cnt == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_hdr_ok ? ST_LOAD : ST_ERROR;
                end
            end
            ST_LOAD: begin
                if (w_ram_we && (r_word_idx == r_last_idx)) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    w_state_nxt = (ld.in_data == r_xor) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_xor      <= 8'd0;
            r_asm      <= 24'd0;
            r_words    <= 7'd0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_byte_cnt <= 2'd0;
                        r_word_idx <= '0;
                        r_xor      <= 8'd0;
                        r_words    <= 7'd0;
                        r_last_idx <= AW'(w_hdr32 - 32'd1);
                    end
                    ST_LOAD: begin
                        r_xor      <= r_xor ^ ld.in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Lane 3 is never stored: it goes straight into the RAM write
                        case (r_byte_cnt)
                            2'd0:    r_asm[7:0]   <= ld.in_data;
                            2'd1:    r_asm[15:8]  <= ld.in_data;
                            2'd2:    r_asm[23:16] <= ld.in_data;
                            default: begin
                                r_word_idx <= r_word_idx + AW'(1);
                                r_words    <= r_words + 7'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (r_word_idx),
        .wdata ({ld.in_data, r_asm}),
        .raddr (w_raddr),
        .rdata (w_ram_rdata)
    );

    assign w_fidx32         = 32'(fetch_addr[FADDR_W-1:2]);
    assign w_raddr          = w_fidx32[AW-1:0];
    assign w_fetch_ok       = (w_fidx32 < 32'(DEPTH));
    assign unused_fetch_lsb = ^fetch_addr[1:0];

    assign core_run     = (r_state == ST_DONE);
    assign load_done    = (r_state == ST_DONE);
    assign load_err     = (r_state == ST_ERROR);
    assign words_loaded = r_words;
    assign fetch_instr  = (core_run && w_fetch_ok) ? w_ram_rdata : NOP_INSTR;

endmodule
`default_nettype wire
